vga_scan_ctrl: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pix_div.sv | 34 +++
 rtl/vga_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and the per-frame update FSM state type.
package vga_timing_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_PIX_DIV  = 2;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_BEG = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END = DEF_H_SYNC_BEG + DEF_H_SYNC;
    localparam int DEF_V_SYNC_BEG = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END = DEF_V_SYNC_BEG + DEF_V_SYNC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } upd_state_e;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-tick divider: counts enabled system clocks 0..PIX_DIV-1 and flags the last one.
module vga_pix_div #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pix_tick
);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_tick = en && (div_q == DIV_MAX);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster sequencer: pixel divider, h/v counters, sync/blank decode and per-frame update handshake.
// Define VGA_SYNC_REG_EN to register position/sync outputs (1 clk latency, pulses delayed to match).
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_tick,
    output logic             line_end,
    output logic             frame_start,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             upd_req,
    input  logic             upd_ack,
    output logic             overrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_REQ_LINE = CNT_W'(V_ACTIVE - 1);

    logic             tick_c, line_end_c, frame_start_c;
    logic             hsync_c, vsync_c, video_on_c;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    upd_state_e       state_q, state_d;
    logic             overrun_q, overrun_d;

    vga_pix_div #(.PIX_DIV(PIX_DIV)) u_pix_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .pix_tick (tick_c)
    );

    assign line_end_c    = tick_c && (h_q == H_LAST);
    assign frame_start_c = line_end_c && (v_q == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick_c) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + CNT_W'(1);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end
        end
    end

    // An ack arriving together with frame_start still counts: the update made it in time.
    always_comb begin
        state_d   = state_q;
        overrun_d = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: if (line_end_c && (v_q == V_REQ_LINE)) state_d = REQ;
                REQ: begin
                    if (upd_ack) begin
                        state_d = DONE;
                    end else if (frame_start_c) begin
                        state_d   = IDLE;
                        overrun_d = 1'b1;
                    end
                end
                DONE: if (frame_start_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign hsync_c    = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    assign vsync_c    = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    assign video_on_c = (h_q < H_ACT) && (v_q < V_ACT);

    assign upd_req = (state_q == REQ);
    assign overrun = overrun_q;

`ifdef VGA_SYNC_REG_EN
    logic [CNT_W-1:0] pixel_x_q, pixel_y_q;
    logic             hsync_q, vsync_q, video_on_q;
    logic             pix_tick_q, line_end_q, frame_start_q;

    // Pulse delays always load so a pulse never repeats while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pix_tick_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= tick_c;
            line_end_q    <= line_end_c;
            frame_start_q <= frame_start_c;
            if (en) begin
                pixel_x_q  <= h_q;
                pixel_y_q  <= v_q;
                hsync_q    <= hsync_c;
                vsync_q    <= vsync_c;
                video_on_q <= video_on_c;
            end
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_tick    = pix_tick_q;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;
`else
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign hsync       = hsync_c;
    assign vsync       = vsync_c;
    assign video_on    = video_on_c;
    assign pix_tick    = tick_c;
    assign line_end    = line_end_c;
    assign frame_start = frame_start_c;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a shrunken raster so many frames fit in a short run.
// Honours VGA_SYNC_REG_EN by shifting the reference outputs by one clock.
module tb_vga_scan_ctrl;

    localparam int PIX_DIV  = 2;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int CNT_W    = 16;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLKS = HT * VT * PIX_DIV;

    typedef struct packed {
        logic             pix_tick;
        logic             line_end;
        logic             frame_start;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             hs;
        logic             vs;
        logic             von;
        logic             req;
        logic             ovr;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             upd_ack = 1'b0;
    logic             pix_tick, line_end, frame_start;
    logic [CNT_W-1:0] pixel_x, pixel_y;
    logic             hsync, vsync, video_on, upd_req, overrun;

    vga_scan_ctrl #(
        .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pix_tick(pix_tick), .line_end(line_end), .frame_start(frame_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .upd_req(upd_req), .upd_ack(upd_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Reference model: raster position is just "ticks since reset" split into line/row.
    int   n_en_clks;
    int   n_ticks;
    bit   req_open;
    bit   served;
    bit   ovr_pending;
    obs_t last_c;
    logic last_en;
    obs_t reg_view;
    obs_t exp_q[$];

    // Stimulus policy knobs.
    int ack_mode;
    int ack_delay;
    int en_drop_pct;
    int spur_pct;
    int wait_cnt;

    function automatic obs_t reset_view();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic obs_t model_comb();
        obs_t o;
        int   h, v;
        h = n_ticks % HT;
        v = (n_ticks / HT) % VT;
        o.pix_tick    = en && ((n_en_clks % PIX_DIV) == PIX_DIV - 1);
        o.line_end    = o.pix_tick && (h == HT - 1);
        o.frame_start = o.line_end && (v == VT - 1);
        o.x   = CNT_W'(h);
        o.y   = CNT_W'(v);
        o.hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        o.vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        o.von = (h < H_ACTIVE) && (v < V_ACTIVE);
        o.req = req_open;
        o.ovr = ovr_pending;
        return o;
    endfunction

    function automatic obs_t model_visible(input obs_t c);
        obs_t o;
`ifdef VGA_SYNC_REG_EN
        o = reg_view;
`else
        o = c;
`endif
        o.req = req_open;
        o.ovr = ovr_pending;
        return o;
    endfunction

    task automatic model_reset();
        n_en_clks   = 0;
        n_ticks     = 0;
        req_open    = 0;
        served      = 0;
        ovr_pending = 0;
        reg_view    = reset_view();
        wait_cnt    = 0;
    endtask

    // Applies one clock edge using the inputs that were held during the cycle just ended.
    task automatic model_advance();
        reg_view.pix_tick    = last_c.pix_tick;
        reg_view.line_end    = last_c.line_end;
        reg_view.frame_start = last_c.frame_start;
        if (last_en) begin
            reg_view.x   = last_c.x;
            reg_view.y   = last_c.y;
            reg_view.hs  = last_c.hs;
            reg_view.vs  = last_c.vs;
            reg_view.von = last_c.von;
        end
        ovr_pending = req_open && last_c.frame_start && !upd_ack;
        if (en) begin
            if (req_open && upd_ack) begin
                req_open = 0;
                served   = 1;
            end else if (last_c.frame_start) begin
                req_open = 0;
                served   = 0;
            end else if (last_c.line_end && last_c.y == CNT_W'(V_ACTIVE - 1) && !served) begin
                req_open = 1;
            end
            n_en_clks++;
            if (last_c.pix_tick) n_ticks++;
        end
    endtask

    task automatic cycle(input bit rst_v, input bit en_low);
        logic e_v, a_v;
        obs_t c;
        @(posedge clk);
        if (rst_n) model_advance();
        #1;
        rst_n = rst_v;
        if (!rst_v) model_reset();
        e_v = !en_low && !rst_v;
        if (e_v && en_drop_pct > 0 && int'($urandom_range(99, 0)) < en_drop_pct) e_v = 1'b0;
        en = e_v;
        c  = model_comb();
        a_v = 1'b0;
        if (req_open) begin
            wait_cnt++;
            case (ack_mode)
                0: a_v = (wait_cnt == ack_delay);
                2: a_v = c.frame_start;
                3: a_v = (int'($urandom_range(99, 0)) < 4);
                default: a_v = 1'b0;
            endcase
        end else begin
            wait_cnt = 0;
            a_v = (spur_pct > 0) && (int'($urandom_range(99, 0)) < spur_pct);
        end
        upd_ack = a_v;
        last_c  = c;
        last_en = en;
        exp_q.push_back(model_visible(c));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    // Monitor: one expected record per clock, compared away from the active edge.
    int  active_ticks;
    bit  frame_counted;

    initial begin
        obs_t a, e;
        active_ticks  = 0;
        frame_counted = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pix_tick = pix_tick;  a.line_end = line_end;  a.frame_start = frame_start;
                a.x = pixel_x;  a.y = pixel_y;  a.hs = hsync;  a.vs = vsync;
                a.von = video_on;  a.req = upd_req;  a.ovr = overrun;
                check("cycle_outputs", 64'(a), 64'(e));
            end
            if (!rst_n) begin
                active_ticks  = 0;
                frame_counted = 1;
            end else begin
                if (pix_tick && video_on) active_ticks++;
                if (frame_start) begin
                    if (frame_counted) check("active_ticks_per_frame", 64'(active_ticks), 64'(H_ACTIVE * V_ACTIVE));
                    active_ticks  = 0;
                    frame_counted = 1;
                end
            end
        end
    end

    initial begin
        ack_mode = 0;  ack_delay = 10;  en_drop_pct = 0;  spur_pct = 0;
        model_reset();
        last_c  = model_comb();
        last_en = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

        // Prompt ack ten clocks into the request.
        run(3 * FRAME_CLKS);

        // No ack at all: overrun once per frame.
        ack_mode = 1;
        run(2 * FRAME_CLKS);

        // Ack lands exactly on frame_start.
        ack_mode = 2;
        run(3 * FRAME_CLKS);

        // Randomised policies, enable gaps and stray acks.
        for (int f = 0; f < 12; f++) begin
            ack_mode    = int'($urandom_range(3, 0));
            ack_delay   = int'($urandom_range(60, 1));
            en_drop_pct = int'($urandom_range(20, 0));
            spur_pct    = 5;
            run(FRAME_CLKS);
        end

        // Mid-line freeze for 100 clocks.
        ack_mode = 0;  ack_delay = 10;  en_drop_pct = 0;  spur_pct = 0;
        for (int i = 0; i < 4 * FRAME_CLKS && !((n_ticks % HT) == 10 && (n_ticks / HT) % VT == 5); i++)
            cycle(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1);
        run(FRAME_CLKS);

        // Reset while a request is pending deep in blanking.
        ack_mode = 1;
        for (int i = 0; i < 4 * FRAME_CLKS && !(req_open && (n_ticks / HT) % VT >= V_ACTIVE + 3); i++)
            cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        ack_mode = 0;
        run(2 * FRAME_CLKS);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
